// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode constants,
// ROB tag width and the common-data-bus bundle with its tag-match helper.
package alu_rs_pkg;

    localparam int unsigned ROB_W = 4;
    localparam int unsigned XLEN  = 32;

    localparam logic [6:0] OP_ARITH_R = 7'b0110011;
    localparam logic [6:0] OP_ARITH_I = 7'b0010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;

    // One result broadcast on the common data bus.
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  val;
        logic [ROB_W-1:0] tag;
    } cdb_t;

    // True when the broadcast is valid and carries the tag being waited on.
    function automatic logic cdb_hit(input cdb_t cdb, input logic [ROB_W-1:0] tag);
        return cdb.valid && (cdb.tag == tag);
    endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Combinational lowest-index priority encoder. Used both to pick the ready
// entry to issue and (with busy bits inverted) the free slot for insertion.
module rs_select #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan high to low so the lowest set request wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU. Holds dispatched ops until both
// operands are valid, snoops the ALU and LSB result buses, and issues at
// most one ready op per cycle (lowest index first).
module alu_rs import alu_rs_pkg::*; #(
    parameter int unsigned RS_SIZE  = 8,
    parameter int unsigned RS_IDX_W = 3,
    parameter int unsigned ROB_W    = alu_rs_pkg::ROB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback_config,

    input  logic             in_config,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_precise,
    input  logic             in_more_precise,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_PC,
    input  logic [ROB_W-1:0] in_rob_entry,
    input  logic [31:0]      in_Vj,
    input  logic [ROB_W-1:0] in_Qj,
    input  logic             in_Qj_busy,
    input  logic [31:0]      in_Vk,
    input  logic [ROB_W-1:0] in_Qk,
    input  logic             in_Qk_busy,

    input  logic             alu_cdb_config,
    input  logic [31:0]      alu_cdb_val,
    input  logic [ROB_W-1:0] alu_cdb_rob_entry,
    input  logic             lsb_cdb_config,
    input  logic [31:0]      lsb_cdb_val,
    input  logic [ROB_W-1:0] lsb_cdb_rob_entry,

    output logic             out_full,
    output logic             out_config,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [31:0]      out_PC,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_precise,
    output logic             out_more_precise,
    output logic [31:0]      out_imm,
    output logic [ROB_W-1:0] out_rob_entry
);

    // Per-entry state
    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_busy;
    logic [RS_SIZE-1:0] r_qk_busy;
    logic [6:0]         r_opcode       [RS_SIZE];
    logic [2:0]         r_precise      [RS_SIZE];
    logic               r_more_precise [RS_SIZE];
    logic [31:0]        r_imm          [RS_SIZE];
    logic [31:0]        r_pc           [RS_SIZE];
    logic [ROB_W-1:0]   r_rob_entry    [RS_SIZE];
    logic [31:0]        r_vj           [RS_SIZE];
    logic [ROB_W-1:0]   r_qj           [RS_SIZE];
    logic [31:0]        r_vk           [RS_SIZE];
    logic [ROB_W-1:0]   r_qk           [RS_SIZE];

    cdb_t                w_alu_cdb;
    cdb_t                w_lsb_cdb;
    logic [RS_SIZE-1:0]  w_ready;
    logic [RS_SIZE-1:0]  w_free;
    logic [RS_IDX_W-1:0] w_issue_idx;
    logic                w_issue_found;
    logic [RS_IDX_W-1:0] w_free_idx;
    logic                w_free_found;
    logic                w_do_insert;
    logic [31:0]         w_ins_vj;
    logic                w_ins_qj_busy;
    logic [31:0]         w_ins_vk;
    logic                w_ins_qk_busy;

    assign w_alu_cdb = '{valid: alu_cdb_config, val: alu_cdb_val, tag: alu_cdb_rob_entry};
    assign w_lsb_cdb = '{valid: lsb_cdb_config, val: lsb_cdb_val, tag: lsb_cdb_rob_entry};

    // Readiness and fullness come from registered state only, so a slot freed
    // or woken this cycle is seen next cycle.
    assign w_ready     = r_busy & ~r_qj_busy & ~r_qk_busy;
    assign w_free      = ~r_busy;
    assign out_full    = &r_busy;
    assign w_do_insert = in_config && w_free_found;

    rs_select #(
        .N     (RS_SIZE),
        .IDX_W (RS_IDX_W)
    ) u_issue_sel (
        .i_req   (w_ready),
        .o_idx   (w_issue_idx),
        .o_found (w_issue_found)
    );

    rs_select #(
        .N     (RS_SIZE),
        .IDX_W (RS_IDX_W)
    ) u_free_sel (
        .i_req   (w_free),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    // Same-cycle forwarding for the op being inserted; ALU bus takes precedence.
    always_comb begin
        w_ins_vj      = in_Vj;
        w_ins_qj_busy = in_Qj_busy;
        w_ins_vk      = in_Vk;
        w_ins_qk_busy = in_Qk_busy;
        if (in_Qj_busy) begin
            if (cdb_hit(w_alu_cdb, in_Qj)) begin
                w_ins_vj      = w_alu_cdb.val;
                w_ins_qj_busy = 1'b0;
            end else if (cdb_hit(w_lsb_cdb, in_Qj)) begin
                w_ins_vj      = w_lsb_cdb.val;
                w_ins_qj_busy = 1'b0;
            end
        end
        if (in_Qk_busy) begin
            if (cdb_hit(w_alu_cdb, in_Qk)) begin
                w_ins_vk      = w_alu_cdb.val;
                w_ins_qk_busy = 1'b0;
            end else if (cdb_hit(w_lsb_cdb, in_Qk)) begin
                w_ins_vk      = w_lsb_cdb.val;
                w_ins_qk_busy = 1'b0;
            end
        end
    end

    // Wakeup, issue and insert; reset and rollback flush everything.
    always_ff @(posedge clk) begin
        if (rst || rollback_config) begin
            r_busy           <= '0;
            out_config       <= 1'b0;
            out_a            <= '0;
            out_b            <= '0;
            out_PC           <= '0;
            out_opcode       <= '0;
            out_precise      <= '0;
            out_more_precise <= 1'b0;
            out_imm          <= '0;
            out_rob_entry    <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (r_busy[i] && r_qj_busy[i]) begin
                    if (cdb_hit(w_alu_cdb, r_qj[i])) begin
                        r_vj[i]      <= w_alu_cdb.val;
                        r_qj_busy[i] <= 1'b0;
                    end else if (cdb_hit(w_lsb_cdb, r_qj[i])) begin
                        r_vj[i]      <= w_lsb_cdb.val;
                        r_qj_busy[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qk_busy[i]) begin
                    if (cdb_hit(w_alu_cdb, r_qk[i])) begin
                        r_vk[i]      <= w_alu_cdb.val;
                        r_qk_busy[i] <= 1'b0;
                    end else if (cdb_hit(w_lsb_cdb, r_qk[i])) begin
                        r_vk[i]      <= w_lsb_cdb.val;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end

            if (w_issue_found) begin
                out_config          <= 1'b1;
                out_a               <= r_vj[w_issue_idx];
                out_b               <= r_vk[w_issue_idx];
                out_PC              <= r_pc[w_issue_idx];
                out_opcode          <= r_opcode[w_issue_idx];
                out_precise         <= r_precise[w_issue_idx];
                out_more_precise    <= r_more_precise[w_issue_idx];
                out_imm             <= r_imm[w_issue_idx];
                out_rob_entry       <= r_rob_entry[w_issue_idx];
                r_busy[w_issue_idx] <= 1'b0;
            end else begin
                out_config <= 1'b0;
            end

            // The free slot is never the issuing slot: one is busy, the other not.
            if (w_do_insert) begin
                r_busy[w_free_idx]         <= 1'b1;
                r_opcode[w_free_idx]       <= in_opcode;
                r_precise[w_free_idx]      <= in_precise;
                r_more_precise[w_free_idx] <= in_more_precise;
                r_imm[w_free_idx]          <= in_imm;
                r_pc[w_free_idx]           <= in_PC;
                r_rob_entry[w_free_idx]    <= in_rob_entry;
                r_vj[w_free_idx]           <= w_ins_vj;
                r_qj[w_free_idx]           <= in_Qj;
                r_qj_busy[w_free_idx]      <= w_ins_qj_busy;
                r_vk[w_free_idx]           <= w_ins_vk;
                r_qk[w_free_idx]           <= in_Qk;
                r_qk_busy[w_free_idx]      <= w_ins_qk_busy;
            end
        end
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the integer ALU.
- Accepts decoded ALU/branch micro-ops from dispatch and holds them until both source operands are valid.
- Captures operands from the common data bus (ALU and LSB result broadcasts).
- Issues at most one ready op per cycle to the ALU using the ALU's issue protocol (config strobe, operands, opcode/funct fields, ROB tag).

Parameters:
- RS_SIZE, 8, number of entries; power of two.
- RS_IDX_W, 3, log2(RS_SIZE).
- ROB_W, 4, ROB tag width.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- rdy in 1: global ready. When low, all state freezes.
- rollback_config in 1: mispredict flush.
- in_config in 1: dispatch valid.
- in_opcode in 7: RISC-V opcode.
- in_precise in 3: funct3.
- in_more_precise in 1: funct7[5].
- in_imm in 32: immediate.
- in_PC in 32: instruction PC.
- in_rob_entry in ROB_W: destination ROB tag.
- in_Vj in 32: operand j value.
- in_Qj in ROB_W: operand j producer tag.
- in_Qj_busy in 1: 1 means Vj is not yet valid.
- in_Vk in 32: operand k value.
- in_Qk in ROB_W: operand k producer tag.
- in_Qk_busy in 1: 1 means Vk is not yet valid.
- alu_cdb_config in 1: ALU result broadcast valid.
- alu_cdb_val in 32: ALU result value.
- alu_cdb_rob_entry in ROB_W: ALU result tag.
- lsb_cdb_config in 1: LSB result broadcast valid.
- lsb_cdb_val in 32: LSB result value.
- lsb_cdb_rob_entry in ROB_W: LSB result tag.
- out_full out 1: no free entry, combinational from busy bits.
- out_config out 1: issue strobe to the ALU.
- out_a out 32: operand j value.
- out_b out 32: operand k value.
- out_PC out 32.
- out_opcode out 7.
- out_precise out 3.
- out_more_precise out 1.
- out_imm out 32.
- out_rob_entry out ROB_W.

Behaviour:
- Reset (rst) and rollback_config, checked in the same clocked branch:
  - All busy bits cleared.
  - All out_* registers zeroed next edge.
  - out_full = 0.
  - Rollback has priority over same-cycle dispatch and issue; both are discarded.
- rdy low: no insert, no wakeup, no issue. All registers hold, including out_config.
- Per entry state: busy, opcode, precise, more_precise, imm, PC, rob_entry, Vj, Qj, Qj_busy, Vk, Qk, Qk_busy.
- Insert:
  - When in_config && rdy && !out_full, the op is written into the lowest-index non-busy entry.
  - Dispatch while out_full is dropped. This is an upstream protocol violation; the bench flags it.
- Same-cycle forwarding on insert:
  - If in_Qj_busy and a valid CDB tag equals in_Qj in that cycle, the entry stores the CDB value with Qj_busy=0.
  - Same rule for k.
  - ALU CDB is checked before LSB. Both matching the same tag is impossible by ROB uniqueness.
- Wakeup:
  - Every cycle, every busy entry with Qx_busy whose Qx matches a valid CDB tag latches Vx and clears Qx_busy.
  - Both CDBs and both operands may wake in one cycle.
- Ready: busy && !Qj_busy && !Qk_busy, evaluated on registered state. An entry woken or inserted this cycle becomes issue-eligible next cycle.
- Select and issue:
  - Pick the lowest-index ready entry.
  - Next edge: out_config=1, out_* = entry fields, entry busy cleared.
  - With no ready entry, out_config=0 and the other outputs hold their last values.
  - Issue latency is 1 cycle from the readiness edge.
- Free-slot reuse: a slot freed by issue is visible as free the following cycle, not the same cycle. out_full reflects registered busy bits only.
- Simultaneous insert and issue in one cycle is allowed and uses different entries.
- Tag width and values are passed through unmodified. No arithmetic is performed in this block.

Decomposition:
- Shared package:
  - Opcode constants: OP_ARITH_R 0110011, OP_ARITH_I 0010011, OP_BRANCH 1100011.
  - ROB_W.
  - CDB bundle fields.
- One sub-module, rs_select: a combinational priority encoder over RS_SIZE ready bits giving idx and found. The same encoder is reused for free-slot selection with the busy bits inverted.

Test Plan:
- Ready op: dispatch ADDI with Vj=5, imm=7, Qj_busy=0, tag 3. Required: next-cycle entry busy, the following edge out_config=1, out_a=5, out_imm=7, out_rob_entry=3.
- CDB wakeup: dispatch ADD with Qj=2 busy and Vk=10. Pulse alu_cdb tag 2, val 0x20. Required: issue one cycle after the broadcast with out_a=0x20, out_b=10.
- Same-cycle forward: dispatch with Qk=6 busy while lsb_cdb tag 6, val 0xFF. Required: no extra wait, and out_b=0xFF on issue.
- Full: fill 8 dependent ops with Qj=9. Required: out_full=1. A 9th dispatch is ignored. Broadcast tag 9. Required: 8 issues on 8 consecutive cycles in index order 0..7.
- Rollback: 4 waiting entries, assert rollback_config with a concurrent dispatch. Required: next cycle out_full=0, out_config=0, and a later tag-matching broadcast produces no issue.
- rdy stall: ready entry present with rdy=0 for 3 cycles. Required: no issue and outputs frozen. Issue occurs the cycle after rdy returns to 1.
